// File: rtl/pong_game_ctrl_if.sv
// Pong game-flow controller bundle.
// Inputs from buttons/physics/scan, outputs to overlay/graphics.
interface pong_game_ctrl_if;
  logic [3:0] btn;
  logic       pts_1;
  logic       pts_2;
  logic [9:0] x;
  logic [9:0] y;
  logic       gra_still;
  logic [3:0] score_1;
  logic [3:0] score_2;
  logic       game_over;
  logic       winner;
  logic [1:0] state;

  modport master (
    output btn, pts_1, pts_2, x, y,
    input  gra_still, score_1, score_2,
    input  game_over, winner, state
  );

  modport slave (
    input  btn, pts_1, pts_2, x, y,
    output gra_still, score_1, score_2,
    output game_over, winner, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: scores, ball freeze,
// game-over and restart timing driven by the frame tick.
module pong_game_ctrl #(
  parameter int WIN_SCORE = 9,
  parameter int BALL_WAIT = 120,
  parameter int OVER_WAIT = 180,
  parameter int TICK_Y    = 481
) (
  input  logic clk,
  input  logic reset,
  pong_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [7:0] BW  = 8'(BALL_WAIT - 1);
  localparam logic [7:0] OW  = 8'(OVER_WAIT);
  localparam logic [9:0] TY  = 10'(TICK_Y);

  state_t     st_q, st_d;
  logic [3:0] s1_q, s1_d;
  logic [3:0] s2_q, s2_d;
  logic [7:0] cnt_q, cnt_d;
  logic       win_q, win_d;
  logic       gs_q;
  logic       go_q;
  logic       pts_1_r, pts_2_r, any_r;
  logic       tick;
  logic       p1_rise, p2_rise, btn_rise;

  assign tick     = (bus.y == TY) && (bus.x == 10'd0);
  assign p1_rise  = bus.pts_1 & ~pts_1_r;
  assign p2_rise  = bus.pts_2 & ~pts_2_r;
  assign btn_rise = (|bus.btn) & ~any_r;

  // Next-state, score and frame-counter decisions
  always_comb begin
    st_d  = st_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    cnt_d = cnt_q;
    win_d = win_q;
    unique case (st_q)
      NEWGAME: begin
        s1_d = 4'd0;
        s2_d = 4'd0;
        if (btn_rise) begin
          st_d = PLAY;
        end
      end
      PLAY: begin
        if (p1_rise) begin
          s1_d  = s1_q + 4'd1;
          cnt_d = 8'd0;
          if (s1_d == WIN) begin
            st_d  = OVER;
            win_d = 1'b0;
          end else begin
            st_d = NEWBALL;
          end
        end else if (p2_rise) begin
          s2_d  = s2_q + 4'd1;
          cnt_d = 8'd0;
          if (s2_d == WIN) begin
            st_d  = OVER;
            win_d = 1'b1;
          end else begin
            st_d = NEWBALL;
          end
        end
      end
      NEWBALL: begin
        if (tick) begin
          if (cnt_q == BW) begin
            st_d = PLAY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      OVER: begin
        if (tick && (cnt_q < OW)) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (btn_rise && (cnt_q == OW)) begin
          st_d  = NEWGAME;
          s1_d  = 4'd0;
          s2_d  = 4'd0;
          cnt_d = 8'd0;
        end
      end
      default: st_d = NEWGAME;
    endcase
  end

  // State, scores and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= NEWGAME;
      s1_q    <= 4'd0;
      s2_q    <= 4'd0;
      cnt_q   <= 8'd0;
      win_q   <= 1'b0;
      gs_q    <= 1'b1;
      go_q    <= 1'b0;
      pts_1_r <= 1'b0;
      pts_2_r <= 1'b0;
      any_r   <= 1'b0;
    end else begin
      st_q    <= st_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      gs_q    <= (st_d != PLAY);
      go_q    <= (st_d == OVER);
      pts_1_r <= bus.pts_1;
      pts_2_r <= bus.pts_2;
      any_r   <= |bus.btn;
    end
  end

  assign bus.state     = st_q;
  assign bus.gra_still = gs_q;
  assign bus.score_1   = s1_q;
  assign bus.score_2   = s2_q;
  assign bus.game_over = go_q;
  assign bus.winner    = win_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: expected outputs queued
// as stimulus is driven, popped after each clock.
module tb_pong_game_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  typedef struct packed {
    logic [1:0] st;
    logic       gs;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       go;
    logic       win;
  } exp_t;

  exp_t exp_q[$];

  pong_game_ctrl_if bus ();

  pong_game_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] st, input logic gs,
                      input logic [3:0] s1, input logic [3:0] s2,
                      input logic go, input logic win);
    exp_t e;
    e.st  = st;
    e.gs  = gs;
    e.s1  = s1;
    e.s2  = s2;
    e.go  = go;
    e.win = win;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_state"}, int'(bus.state), int'(e.st));
      chk({tag, "_still"}, int'(bus.gra_still), int'(e.gs));
      chk({tag, "_s1"}, int'(bus.score_1), int'(e.s1));
      chk({tag, "_s2"}, int'(bus.score_2), int'(e.s2));
      chk({tag, "_over"}, int'(bus.game_over), int'(e.go));
      if (e.go) begin
        chk({tag, "_winner"}, int'(bus.winner), int'(e.win));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.x = 10'd0;
    bus.y = 10'd481;
    step();
    bus.x = 10'd5;
    bus.y = 10'd0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    reset     = 1'b0;
    bus.btn   = 4'd0;
    bus.pts_1 = 1'b0;
    bus.pts_2 = 1'b0;
    bus.x     = 10'd5;
    bus.y     = 10'd0;
    repeat (3) step();
    push(2'd0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    pop_chk("rst_hold");
    reset = 1'b1;
    push(2'd0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    step();
    pop_chk("newgame");
    bus.btn = 4'b0001;
    push(2'd1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    step();
    pop_chk("start");
    bus.btn = 4'd0;

    bus.pts_1 = 1'b1;
    push(2'd2, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    step();
    pop_chk("p1_score");
    repeat (498) step();
    bus.pts_1 = 1'b0;
    push(2'd2, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    step();
    pop_chk("p1_once");
    push(2'd2, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    tick();
    pop_chk("tick1");
    ticks(117);
    push(2'd2, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    tick();
    pop_chk("tick119");
    push(2'd1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0);
    tick();
    pop_chk("tick120");

    bus.pts_1 = 1'b1;
    bus.pts_2 = 1'b1;
    push(2'd2, 1'b1, 4'd2, 4'd0, 1'b0, 1'b0);
    step();
    pop_chk("both");
    bus.pts_1 = 1'b0;
    bus.pts_2 = 1'b0;
    step();
    bus.pts_2 = 1'b1;
    push(2'd2, 1'b1, 4'd2, 4'd0, 1'b0, 1'b0);
    step();
    pop_chk("nb_p2");
    bus.pts_2 = 1'b0;
    ticks(119);
    push(2'd1, 1'b0, 4'd2, 4'd0, 1'b0, 1'b0);
    tick();
    pop_chk("back_play");

    for (int i = 1; i <= 8; i++) begin
      bus.pts_2 = 1'b1;
      push(2'd2, 1'b1, 4'd2, 4'(i), 1'b0, 1'b0);
      step();
      pop_chk("p2_pt");
      bus.pts_2 = 1'b0;
      ticks(119);
      push(2'd1, 1'b0, 4'd2, 4'(i), 1'b0, 1'b0);
      tick();
      pop_chk("p2_play");
    end
    bus.pts_2 = 1'b1;
    push(2'd3, 1'b1, 4'd2, 4'd9, 1'b1, 1'b1);
    step();
    pop_chk("p2_win");
    bus.pts_2 = 1'b0;

    ticks(100);
    bus.btn = 4'b0100;
    push(2'd3, 1'b1, 4'd2, 4'd9, 1'b1, 1'b1);
    step();
    pop_chk("btn_t100");
    bus.btn = 4'd0;
    step();
    ticks(79);
    bus.btn = 4'b0100;
    push(2'd3, 1'b1, 4'd2, 4'd9, 1'b1, 1'b1);
    step();
    pop_chk("btn_t179");
    bus.btn = 4'd0;
    step();
    tick();
    bus.btn = 4'b1000;
    push(2'd0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    step();
    pop_chk("restart");
    for (int i = 0; i < 3; i++) begin
      push(2'd0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
      step();
      pop_chk("held");
    end
    bus.btn = 4'd0;
    push(2'd0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    step();
    pop_chk("release");
    bus.btn = 4'b0010;
    push(2'd1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    step();
    pop_chk("repress");
    bus.btn = 4'd0;

    bus.pts_1 = 1'b1;
    push(2'd2, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    step();
    pop_chk("p1_again");
    bus.pts_1 = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    push(2'd0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    pop_chk("async_rst");
    step();
    reset = 1'b1;
    push(2'd0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    step();
    pop_chk("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
